// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: IEEE-style floating-point add/subtract (flush-to-zero), W = 1+EXP_W+MAN_W.
// Latency 3 cycles accept-to-result (S1 align, S2 add/LZC, S3 normalise/round/pack), 1 result/cycle.
// Backpressure: in_ready = !out_valid || out_ready; empty stages still advance. FP_ADDSUB_RNE_EN selects RNE, else truncate.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op_sub,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 4;          // hidden + fraction + guard/round/sticky
  localparam int LZW = $clog2(SW + 2);
  localparam int XW  = EXP_W + 8;          // signed headroom for exponent adjust
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  // Stage handshake: a stage may load when the stage after it moves or when it is empty
  logic v1_q, v2_q, v3_q, en1, en2, en3;
  assign en3       = !v3_q || out_ready;
  assign en2       = en3 || !v2_q;
  assign en1       = en2 || !v1_q;
  assign in_ready  = en3;
  assign out_valid = v3_q;

  // ---------------- S1: unpack / classify / compare / swap / align ----------------
  logic [EXP_W-1:0] ea, eb, e_big, e_sml, diff;
  logic [MAN_W-1:0] fa, fb;
  logic [MAN_W:0]   sig_a, sig_b, sig_big, sig_sml;
  logic             sa, sb, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, swap, sign_d;
  logic [2*SW-1:0]  wide;
  logic [SW-1:0]    al_d;
  logic             spec_d, sinv_d;
  logic [W-1:0]     sres_d;

  assign ea     = a[W-2:MAN_W];
  assign eb     = b[W-2:MAN_W];
  assign fa     = a[MAN_W-1:0];
  assign fb     = b[MAN_W-1:0];
  assign sa     = a[W-1];
  assign sb     = b[W-1] ^ op_sub;
  assign a_nan  = (ea == EMAX) && (fa != '0);
  assign b_nan  = (eb == EMAX) && (fb != '0);
  assign a_snan = a_nan && !fa[MAN_W-1];
  assign b_snan = b_nan && !fb[MAN_W-1];
  assign a_inf  = (ea == EMAX) && (fa == '0);
  assign b_inf  = (eb == EMAX) && (fb == '0);
  // Subnormals (exponent 0) become zero significands
  assign sig_a  = (ea != '0) ? {1'b1, fa} : '0;
  assign sig_b  = (eb != '0) ? {1'b1, fb} : '0;
  // Order by full magnitude so the larger operand fixes exponent and sign
  assign swap    = {eb, sig_b} > {ea, sig_a};
  assign e_big   = swap ? eb : ea;
  assign e_sml   = swap ? ea : eb;
  assign sig_big = swap ? sig_b : sig_a;
  assign sig_sml = swap ? sig_a : sig_b;
  assign sign_d  = swap ? sb : sa;
  assign diff    = e_big - e_sml;
  // Low half of the wide shift holds the bits that fall off; they fold into sticky
  assign wide    = {sig_sml, 3'b000, {SW{1'b0}}} >> diff;
  assign al_d    = (int'(diff) >= SW - 1) ? {{(SW-1){1'b0}}, |sig_sml}
                 : (wide[2*SW-1:SW] | {{(SW-1){1'b0}}, |wide[SW-1:0]});

  // NaN / infinity results bypass the arithmetic path
  always_comb begin
    spec_d = 1'b1;
    sinv_d = 1'b0;
    sres_d = QNAN;
    if (a_nan || b_nan)                    sinv_d = a_snan || b_snan;
    else if (a_inf && b_inf && (sa != sb)) sinv_d = 1'b1;
    else if (a_inf)                        sres_d = {sa, EMAX, {MAN_W{1'b0}}};
    else if (b_inf)                        sres_d = {sb, EMAX, {MAN_W{1'b0}}};
    else                                   spec_d = 1'b0;
  end

  logic             sign1_q, zsign1_q, sub1_q, spec1_q, sinv1_q;
  logic [EXP_W-1:0] exp1_q;
  logic [SW-1:0]    big1_q, sml1_q;
  logic [W-1:0]     sres1_q;

  // ---------------- S2: add / subtract and leading-zero count ----------------
  logic [SW:0]      sum_d;
  logic [LZW-1:0]   lz_d;

  // Magnitudes are ordered, so the difference never goes negative
  always_comb begin
    sum_d = sub1_q ? ({1'b0, big1_q} - {1'b0, sml1_q}) : ({1'b0, big1_q} + {1'b0, sml1_q});
    lz_d  = LZW'(SW + 1);
    for (int i = 0; i <= SW; i++) begin
      if (sum_d[i]) lz_d = LZW'(SW - i);
    end
  end

  logic             sign2_q, zsign2_q, spec2_q, sinv2_q;
  logic [EXP_W-1:0] exp2_q;
  logic [SW:0]      sum2_q;
  logic [LZW-1:0]   lz2_q;
  logic [W-1:0]     sres2_q;

  // ---------------- S3: normalise / round / pack ----------------
  logic [SW-1:0]    norm;
  logic [XW-1:0]    exp_n, exp_r;
  logic [MAN_W+1:0] rnd;
  logic [MAN_W-1:0] frac;
  logic             inexact, inc;
  logic [W-1:0]     res_d;
  logic [3:0]       flg_d;

  // Carry-out shifts right one place; cancellation shifts left by the leading-zero count
  always_comb begin
    if (sum2_q[SW]) begin
      norm  = {sum2_q[SW:2], sum2_q[1] | sum2_q[0]};
      exp_n = {{(XW-EXP_W){1'b0}}, exp2_q} + XW'(1);
    end else begin
      norm  = sum2_q[SW-1:0] << (lz2_q - LZW'(1));
      exp_n = {{(XW-EXP_W){1'b0}}, exp2_q} - {{(XW-LZW){1'b0}}, lz2_q} + XW'(1);
    end
    inexact = norm[2] | norm[1] | norm[0];
`ifdef FP_ADDSUB_RNE_EN
    inc = norm[2] & (norm[1] | norm[0] | norm[3]);
`else
    inc = 1'b0;
`endif
    rnd = {1'b0, norm[SW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
    if (rnd[MAN_W+1]) begin
      exp_r = exp_n + XW'(1);
      frac  = rnd[MAN_W:1];
    end else begin
      exp_r = exp_n;
      frac  = rnd[MAN_W-1:0];
    end
    if (spec2_q) begin
      res_d = sres2_q;
      flg_d = {sinv2_q, 3'b000};
    end else if (sum2_q == '0) begin
      res_d = {zsign2_q, {(W-1){1'b0}}};
      flg_d = 4'b0000;
    end else if (!exp_r[XW-1] && (exp_r >= {{(XW-EXP_W){1'b0}}, EMAX})) begin
      res_d = {sign2_q, EMAX, {MAN_W{1'b0}}};
      flg_d = 4'b0101;
    end else if (exp_r[XW-1] || (exp_r == '0)) begin
      res_d = {sign2_q, {(W-1){1'b0}}};
      flg_d = 4'b0011;
    end else begin
      res_d = {sign2_q, exp_r[EXP_W-1:0], frac};
      flg_d = {3'b000, inexact};
    end
  end

  logic [W-1:0] result_q;
  logic [3:0]   flags_q;
  assign result = result_q;
  assign flags  = flags_q;

  // Valid bits and output register; output holds while out_valid && !out_ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      if (en1) v1_q <= in_valid && in_ready;
      if (en2) v2_q <= v1_q;
      if (en3) begin
        v3_q <= v2_q;
        if (v2_q) begin
          result_q <= res_d;
          flags_q  <= flg_d;
        end
      end
    end
  end

  // Datapath stage registers; contents only matter while the matching valid bit is set
  always_ff @(posedge clk) begin
    if (en1) begin
      sign1_q  <= sign_d;
      zsign1_q <= sa & sb;
      sub1_q   <= sa ^ sb;
      exp1_q   <= e_big;
      big1_q   <= {sig_big, 3'b000};
      sml1_q   <= al_d;
      spec1_q  <= spec_d;
      sinv1_q  <= sinv_d;
      sres1_q  <= sres_d;
    end
    if (en2) begin
      sign2_q  <= sign1_q;
      zsign2_q <= zsign1_q;
      exp2_q   <= exp1_q;
      sum2_q   <= sum_d;
      lz2_q    <= lz_d;
      spec2_q  <= spec1_q;
      sinv2_q  <= sinv1_q;
      sres2_q  <= sres1_q;
    end
  end
endmodule
